mux_arbiter_2x1: RTL and testbench
==================================

# mux_arbiter_2x1

Two-requester round-robin arbiter that shares the 2:1 select datapath between two sources and drives its select line. It registers grant ownership, forwards the owner's data through the mux to a single downstream consumer with a valid/ready handshake, and optionally bounds each grant to a fixed burst length. It sits directly in front of the 2:1 mux and owns its `s` input.

## Interface
Parameters:
- `WIDTH`, 8: data width of each source and the output.
- `MAX_BURST`, 4: beats per grant before forced release. Legal range is 1..255. It is used only with `ARB_BURST_LIMIT_EN`.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req0`, `req1` input, 1 bit each: requester wants the resource and has a valid beat presented.
- `data0`, `data1` input, `WIDTH` bits each: requester data.
- `ready` input, 1 bit: downstream accepts a beat this cycle.
- `gnt0`, `gnt1` output, 1 bit each: registered one-hot-or-zero ownership.
- `sel` output, 1 bit: mux select. 0 selects source 0, 1 selects source 1.
- `out_valid` output, 1 bit: the current owner presents a beat.
- `out_data` output, `WIDTH` bits: `sel ? data1 : data0`.

## Operation
- **States:** IDLE, OWN0, OWN1, held in a registered state. `gnt0` = (state==OWN0). `gnt1` = (state==OWN1). `sel` = (state==OWN1).
- **Combinational outputs:**
  - `out_valid` = (OWN0 & `req0`) | (OWN1 & `req1`).
  - `out_data` follows `sel` combinationally.
- **Beat:** a beat is `out_valid & ready`.
- **Priority pointer:** `last` names the most recently granted source. Reset value is 1, so source 0 wins the first contention.
- **IDLE:**
  - Only `req0` asserted: go to OWN0.
  - Only `req1` asserted: go to OWN1.
  - Both asserted: go to the source ≠ `last`.
  - Neither asserted: stay in IDLE.
  - On entering OWNx, set `last`=x.
- **OWNx, release when:**
  - `reqx`=0, or
  - a burst-limit release occurs (see Configuration).
- **OWNx, on release:**
  - If the other request is asserted, go directly to OWN(other) in the same edge and set `last`=other.
  - Otherwise go to IDLE.
- **Beat counter:** `cnt` has width `$clog2(MAX_BURST+1)`. It increments on each beat and clears to 0 on every state change.
- **Ordering:** no beat is lost or duplicated across a grant change.
  - A beat occurring on the same cycle the owner's `req` is high completes before release.
  - `req` dropping with `ready` high produces no beat, because `out_valid` is already 0.
- **Reset values (asynchronous, while `rst_n`=0):**
  - state=IDLE, `gnt0`=`gnt1`=0, `sel`=0, `out_valid`=0.
  - `cnt`=0, `last`=1.
  - `out_data` equals `data0`.

## Timing
- **Grant latency:** `req0` first sampled high at edge n in IDLE → `gnt0`=1 and `out_valid`=1 after edge n. This is 1 cycle of grant latency.
- **Throughput:** with `ready`=1, one beat per cycle while owned.
- **Release on request drop:** `reqx` deasserts before edge m → state changes after edge m. There are no idle cycles between owners when the other source is waiting.
- **Stall:** `ready`=0 holds ownership, `cnt`, and all outputs stable. `out_valid` stays high while `reqx` is high.
- **Reset mid-burst:** outputs go to reset values immediately and asynchronously. The first grant after `rst_n` rises follows the IDLE rules, with source 0 preferred.

## Configuration
- **With `ARB_BURST_LIMIT_EN` defined:**
  - A beat that brings `cnt` to `MAX_BURST` forces release at that edge, even if `reqx` stays high.
  - If the other source is waiting, ownership passes to it.
  - If not, the state goes to IDLE. The same source is re-granted one edge later, giving one bubble cycle.
- **Without it:**
  - No counter is built.
  - Ownership is held until the owner drops `req`. This makes the block a lock-until-done arbiter.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-operation → `gnt0`=`gnt1`=`sel`=`out_valid`=0 immediately. After release, `req0`=`req1`=1 → `gnt0`=1 after one edge.
- **Single source:** `req0`=1, `ready`=1, `data0`=8'hA5 for 3 cycles → `out_valid`=1 and `out_data`=8'hA5 on 3 consecutive cycles. After `req0` drops, state returns to IDLE the next edge.
- **Contention without the burst limit:** `req0`=`req1`=1 constantly.
  - Result: `gnt0` holds until `req0` drops.
  - Then `gnt1` asserts on that same edge with `sel`=1.
- **Burst limit:** `ARB_BURST_LIMIT_EN` defined, `MAX_BURST`=4, both requesting, `ready`=1.
  - Expected grant pattern: 4 beats on `gnt0`, 4 on `gnt1`, 4 on `gnt0`, and so on.
- **Stall:** `ready`=0 for 5 cycles mid-burst → no grant change, `cnt` frozen. Once `ready` returns, exactly the remaining `MAX_BURST` − `cnt` beats occur before the switch.
- **Lone requester at the limit:** only `req1` asserted with the burst limit and `MAX_BURST`=2.
  - Expected: 2 beats, then 1 IDLE cycle, then `gnt1` again. This repeats.

Source files
------------

// File: rtl/mux_arbiter_2x1.sv
// Two-source round-robin arbiter that owns the select line of a 2:1 data mux; optional burst bound via ARB_BURST_LIMIT_EN.
// Latency: grant one edge after a request is sampled in IDLE; data/valid pass combinationally from the owner.
// Backpressure: ready=0 freezes ownership, the beat counter and all outputs; release only when the owner drops req (or hits the burst bound).
module mux_arbiter_2x1 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Burst length is stored in an 8-bit-or-narrower counter; reject nonsense at elaboration.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST must be in 1..255");
    end

    state_t state_q, state_d;
    logic   last_q, last_d;      // most recently granted source; 1 at reset so source 0 wins first
    logic   burst_rel;           // owner must let go at this edge because its burst is used up

    // Grant and select are pure decodes of the state flop, so they never glitch.
    assign gnt0      = (state_q == OWN0);
    assign gnt1      = (state_q == OWN1);
    assign sel       = gnt1;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign out_data  = sel ? data1 : data0;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic          beat;
    logic [CW-1:0] cnt_q, cnt_d;

    assign beat      = out_valid & ready;
    // The beat that brings the count to MAX_BURST is the last one of this grant.
    assign burst_rel = beat && ((cnt_q + CW'(1)) == CW'(MAX_BURST));
`else
    // Lock-until-done: ownership only ends when the owner drops its request.
    assign burst_rel = 1'b0;
`endif

    // Next-state selection: round-robin on contention, direct hand-over on release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
                else if (req0)     state_d = OWN0;
                else if (req1)     state_d = OWN1;
            end
            OWN0: if (!req0 || burst_rel) state_d = req1 ? OWN1 : IDLE;
            OWN1: if (!req1 || burst_rel) state_d = req0 ? OWN0 : IDLE;
            default:                      state_d = IDLE;
        endcase
        // The pointer only moves when a grant is actually handed out.
        if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
        if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;
    end

`ifdef ARB_BURST_LIMIT_EN
    // Count beats within the current grant; any ownership change starts a fresh burst.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (beat)          cnt_d = cnt_q + CW'(1);
    end
`endif

    // All arbiter state in one register bank with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
`ifdef ARB_BURST_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef ARB_BURST_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux_arbiter_2x1.sv
// Bench for mux_arbiter_2x1: directed grant patterns plus random traffic against an ownership model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Works for both builds; burst-specific expectations follow ARB_BURST_LIMIT_EN.
module tb_mux_arbiter_2x1;

    localparam int W  = 8;
    localparam int MB = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, ready = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, sel, out_valid;
    logic [W-1:0] out_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_arbiter_2x1 #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .ready(ready),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .out_valid(out_valid), .out_data(out_data)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- ownership model ----------------
    typedef struct packed {
        logic       busy;   // someone owns the resource
        logic       who;    // which source owns it
        logic       last;   // last source granted
        logic [8:0] beats;  // beats delivered in current grant
    } mst_t;

    function automatic mst_t m_next(mst_t s, logic r0, logic r1, logic rdy);
        mst_t       n = s;
        logic [1:0] r = {r1, r0};
        logic       bt;
        logic       go;
        if (!s.busy) begin
            if (r == 2'b11) begin n.busy = 1'b1; n.who = ~s.last; end
            else if (r != 2'b00) begin n.busy = 1'b1; n.who = r[1]; end
        end else begin
            bt = r[s.who] & rdy;
            n.beats = s.beats + 9'(bt);
            go = ~r[s.who];
            if (BURST && bt && n.beats >= 9'(MB)) go = 1'b1;
            if (go) begin
                if (r[~s.who]) n.who = ~s.who;
                else           n.busy = 1'b0;
            end
        end
        if (n.busy != s.busy || n.who != s.who) begin
            n.beats = '0;
            if (n.busy) n.last = n.who;
        end
        return n;
    endfunction

    mst_t m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{busy: 1'b0, who: 1'b0, last: 1'b1, beats: 9'd0};
        else        m <= m_next(m, req0, req1, ready);
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        check("m_gnt0", gnt0, m.busy & ~m.who);
        check("m_gnt1", gnt1, m.busy & m.who);
        check("m_sel",  sel,  m.busy & m.who);
        check("m_valid", out_valid, m.busy & (m.who ? req1 : req0));
        check("m_data", out_data, (m.busy & m.who) ? data1 : data0);
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_sel", sel, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, data0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int nb;
        data0 = 8'h3C;
        data1 = 8'hC3;
        #1 rst_n = 1'b0;
        #1;
        check("init_gnt0", gnt0, 0);
        check("init_gnt1", gnt1, 0);
        check("init_valid", out_valid, 0);
        check("init_data", out_data, 8'h3C);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single source, three beats of A5
        req0 = 1'b1; ready = 1'b1; data0 = 8'hA5; data1 = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check("single_gnt0", gnt0, 1);
            check("single_valid", out_valid, 1);
            check("single_data", out_data, 8'hA5);
        end
        req0 = 1'b0;
        tick(); #1;
        check("single_idle_gnt0", gnt0, 0);
        check("single_idle_gnt1", gnt1, 0);
        check("single_idle_valid", out_valid, 0);

        // last now points at source 0, so contention grants source 1; reset mid-grant
        req0 = 1'b1; req1 = 1'b1;
        tick(); #1;
        check("pre_rst_gnt1", gnt1, 1);
        do_reset();
        tick(); #1;
        check("post_rst_gnt0", gnt0, 1);
        check("post_rst_sel", sel, 0);

        // contention
`ifdef ARB_BURST_LIMIT_EN
        for (int k = 2; k <= 12; k++) begin
            logic e;
            tick(); #1;
            e = ((((k - 1) / MB) % 2) == 1);
            check("burst_gnt0", gnt0, ~e);
            check("burst_gnt1", gnt1, e);
            check("burst_data", out_data, e ? 8'h5A : 8'hA5);
        end
`else
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check("lock_gnt0", gnt0, 1);
        end
        req0 = 1'b0;
        tick(); #1;
        check("handover_gnt1", gnt1, 1);
        check("handover_sel", sel, 1);
        check("handover_data", out_data, 8'h5A);
`endif

        // stall mid-burst: two beats, five stalled cycles, then the remainder
        req0 = 1'b1; req1 = 1'b1; ready = 1'b1;
        do_reset();
        tick(); tick(); tick();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            check("stall_gnt0", gnt0, 1);
            check("stall_valid", out_valid, 1);
        end
        ready = 1'b1;
        nb = 0;
`ifdef ARB_BURST_LIMIT_EN
        for (int k = 0; k < 10; k++) begin
            if (gnt0 && out_valid) nb++;
            tick(); #1;
            if (!gnt0) break;
        end
        check("stall_remaining_beats", nb, MB - 2);
        check("stall_switch_gnt1", gnt1, 1);
`else
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            if (gnt0 && out_valid) nb++;
        end
        check("stall_lock_beats", nb, 3);
`endif

        // lone requester on source 1
        req0 = 1'b0; req1 = 1'b1; ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick(); #1;
            check("lone_gnt1", gnt1, (BURST && (k % (MB + 1)) == 0) ? 0 : 1);
        end

        // random traffic with sticky requests, one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            ready = ($urandom_range(0, 3) != 0);
            data0 = W'($urandom);
            data1 = W'($urandom);
            if (i == 1500) do_reset();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
